// File: rtl/game_referee_pkg.sv
// Shared encodings for the rock/scissors/paper referee: moves, results,
// FSM states, counter sizing and a saturating increment helper.
package game_referee_pkg;

  // Move encoding shared by the user selector and the move engine.
  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    SCISSORS = 2'b01,
    PAPER    = 2'b10,
    ILLEGAL  = 2'b11
  } move_e;

  // Round outcome as reported on the result port.
  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_USER = 2'b01,
    RES_COMP = 2'b10,
    RES_TIE  = 2'b11
  } result_e;

  // Referee FSM states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ENG = 3'd1,
    JUDGE    = 3'd2,
    RELEASE  = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int              CNT_W   = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counters stop at their maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_referee_key_sync.sv
// Two-flop synchronizer for the active-low play key plus a falling-edge
// detector producing a single-cycle press pulse.
module game_referee_key_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Resynchronize the raw key; all flops idle high (key released).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Press is the synchronized high-to-low transition.
  assign o_press = r_prev & ~r_sync2;

endmodule

// File: rtl/game_referee.sv
// Rock/scissors/paper match referee. Accepts a user move on a key press,
// requests an engine move, judges the round and keeps the match score.
//
// Engine handshake: start is a level request held high only in WAIT_ENG.
// The engine answers by raising engine_ready with engine_choice valid; the
// referee latches the move on the first edge it sees ready high and drops
// start on that same edge. A new request is only issued after engine_ready
// has been observed low again (RELEASE), so every request/answer pair is a
// full four-phase exchange.
module game_referee
  import game_referee_pkg::*;
#(
  parameter int MAX_GAMES = 60,
  parameter int TIMEOUT   = 1023
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_play,
  input  logic [1:0]       user_sel,
  input  logic             engine_ready,
  input  logic [1:0]       engine_choice,
  output logic             start,
  output logic [1:0]       user_choice,
  output logic [1:0]       comp_choice,
  output logic [1:0]       result,
  output logic [CNT_W-1:0] user_score,
  output logic [CNT_W-1:0] comp_score,
  output logic [CNT_W-1:0] tie_count,
  output logic [CNT_W-1:0] game_no,
  output logic             busy,
  output logic             game_over,
  output logic             err,
  output state_e           dbg_state
);

  localparam int               TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_GAMES_C = CNT_W'(MAX_GAMES);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_press;
  logic             w_accept;
  logic             w_eng_take;
  logic             w_timeout;
  logic             w_judge;
  logic             w_comp_legal;
  result_e          w_outcome;
  logic [CNT_W-1:0] w_game_no_inc;

  logic             r_start;
  move_e            r_user_choice;
  move_e            r_comp_choice;
  result_e          r_result;
  logic [CNT_W-1:0] r_user_score;
  logic [CNT_W-1:0] r_comp_score;
  logic [CNT_W-1:0] r_tie_count;
  logic [CNT_W-1:0] r_game_no;
  logic             r_busy;
  logic             r_game_over;
  logic             r_err;
  logic [TW-1:0]    r_tmo_cnt;

  game_referee_key_sync u_key_sync (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_key_n (key_play),
    .o_press (w_press)
  );

  assign w_game_no_inc = sat_inc(r_game_no);
  assign w_comp_legal  = (r_comp_choice != ILLEGAL);

  // Winner decode on the latched moves; evaluated during JUDGE.
  always_comb begin
    w_outcome = RES_NONE;
    if (w_comp_legal && (r_user_choice != ILLEGAL)) begin
      if (r_user_choice == r_comp_choice) begin
        w_outcome = RES_TIE;
      end else begin
        case ({r_user_choice, r_comp_choice})
          {ROCK, SCISSORS},
          {SCISSORS, PAPER},
          {PAPER, ROCK}:     w_outcome = RES_USER;
          default:           w_outcome = RES_COMP;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_eng_take   = 1'b0;
    w_timeout    = 1'b0;
    w_judge      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press && (user_sel != ILLEGAL)) begin
          w_accept     = 1'b1;
          w_state_next = WAIT_ENG;
        end
      end
      WAIT_ENG: begin
        if (engine_ready) begin
          w_eng_take   = 1'b1;
          w_state_next = JUDGE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = RELEASE;
        end
      end
      JUDGE: begin
        w_judge = 1'b1;
        if (w_comp_legal && (w_game_no_inc == MAX_GAMES_C)) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!engine_ready) begin
          w_state_next = IDLE;
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: status flags follow the next state so they are glitch-free
  // registers aligned with the state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_start       <= 1'b0;
      r_busy        <= 1'b0;
      r_game_over   <= 1'b0;
      r_err         <= 1'b0;
      r_user_choice <= ROCK;
      r_comp_choice <= ROCK;
      r_result      <= RES_NONE;
      r_user_score  <= '0;
      r_comp_score  <= '0;
      r_tie_count   <= '0;
      r_game_no     <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      r_start     <= (w_state_next == WAIT_ENG);
      r_busy      <= (w_state_next != IDLE) && (w_state_next != DONE);
      r_game_over <= (w_state_next == DONE);

      if (w_accept) begin
        r_user_choice <= move_e'(user_sel);
        r_tmo_cnt     <= '0;
      end else if (r_state == WAIT_ENG) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (w_eng_take) begin
        r_comp_choice <= move_e'(engine_choice);
      end

      if (w_timeout) begin
        r_result <= RES_NONE;
        r_err    <= 1'b1;
      end

      if (w_judge) begin
        r_result <= w_outcome;
        if (!w_comp_legal) begin
          r_err <= 1'b1;
        end else begin
          r_game_no <= w_game_no_inc;
          case (w_outcome)
            RES_USER: r_user_score <= sat_inc(r_user_score);
            RES_COMP: r_comp_score <= sat_inc(r_comp_score);
            RES_TIE:  r_tie_count  <= sat_inc(r_tie_count);
            default:  ;
          endcase
        end
      end
    end
  end

  assign start       = r_start;
  assign user_choice = r_user_choice;
  assign comp_choice = r_comp_choice;
  assign result      = r_result;
  assign user_score  = r_user_score;
  assign comp_score  = r_comp_score;
  assign tie_count   = r_tie_count;
  assign game_no     = r_game_no;
  assign busy        = r_busy;
  assign game_over   = r_game_over;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: scenario tasks with a scoreboard of expected
// round outcomes {result, user, comp, tie, game_no, err}.
module tb_game_referee;
  import game_referee_pkg::*;

  localparam int MAXG = 3;
  localparam int TMO  = 1023;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_play = 1'b1;
  logic [1:0] user_sel = 2'b00;
  logic       engine_ready = 1'b0;
  logic [1:0] engine_choice = 2'b00;
  logic       start;
  logic [1:0] user_choice;
  logic [1:0] comp_choice;
  logic [1:0] result;
  logic [5:0] user_score;
  logic [5:0] comp_score;
  logic [5:0] tie_count;
  logic [5:0] game_no;
  logic       busy;
  logic       game_over;
  logic       err;
  state_e     dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int last_lat = 0;

  logic [26:0] exp_q[$];
  logic [5:0]  m_user, m_comp, m_tie, m_game;
  logic        m_err;

  game_referee #(.MAX_GAMES(MAXG), .TIMEOUT(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .key_play      (key_play),
    .user_sel      (user_sel),
    .engine_ready  (engine_ready),
    .engine_choice (engine_choice),
    .start         (start),
    .user_choice   (user_choice),
    .comp_choice   (comp_choice),
    .result        (result),
    .user_score    (user_score),
    .comp_score    (comp_score),
    .tie_count     (tie_count),
    .game_no       (game_no),
    .busy          (busy),
    .game_over     (game_over),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Rock-scissors-paper rules written out as the winning pairs.
  function automatic logic [1:0] ref_result(input logic [1:0] u, input logic [1:0] e);
    if (u == 2'b11 || e == 2'b11) return 2'b00;
    if (u == e) return 2'b11;
    if ((u == 2'b00 && e == 2'b01) || (u == 2'b01 && e == 2'b10) ||
        (u == 2'b10 && e == 2'b00)) return 2'b01;
    return 2'b10;
  endfunction

  task automatic model_reset();
    m_user = '0; m_comp = '0; m_tie = '0; m_game = '0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_round(input logic [1:0] u, input logic [1:0] e);
    logic [1:0] r;
    r = ref_result(u, e);
    if (r == 2'b00) begin
      m_err = 1'b1;
    end else begin
      if (r == 2'b01 && m_user != 6'd63) m_user = m_user + 1'b1;
      if (r == 2'b10 && m_comp != 6'd63) m_comp = m_comp + 1'b1;
      if (r == 2'b11 && m_tie  != 6'd63) m_tie  = m_tie + 1'b1;
      if (m_game != 6'd63) m_game = m_game + 1'b1;
    end
    exp_q.push_back({r, m_user, m_comp, m_tie, m_game, m_err});
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0; key_play = 1'b1; engine_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  // Press the key at a negedge; lat = negedges until start seen high (0 = never).
  task automatic press_and_wait(output int lat, input int bound);
    lat = 0;
    @(negedge clock);
    key_play = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clock);
      if (i == 4) key_play = 1'b1;
      if (start === 1'b1) begin
        lat = i;
        break;
      end
    end
    key_play = 1'b1;
  endtask

  // One full round: press, engine answers after delay, ready held for hold cycles.
  task automatic play_round(input logic [1:0] u, input logic [1:0] e,
                            input int delay, input int hold, input string tag);
    int lat;
    logic [26:0] exp_v, act_v;
    user_sel = u;
    press_and_wait(lat, 20);
    last_lat = lat;
    n_checks++;
    if (lat == 0) begin
      $display("FAIL %s start: got no start within 20 cycles, expected start high", tag);
      return;
    end
    n_pass++;
    repeat (delay) @(negedge clock);
    engine_choice = e;
    engine_ready  = 1'b1;
    model_round(u, e);
    @(negedge clock);
    n_checks++;
    if ({start, comp_choice} !== {1'b0, e})
      $display("FAIL %s ready_edge: got start=%b comp=%b, expected start=0 comp=%b",
               tag, start, comp_choice, e);
    else n_pass++;
    if (hold == 0) engine_ready = 1'b0;
    @(negedge clock);
    act_v = {result, user_score, comp_score, tie_count, game_no, err};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard: got %h, expected queue empty", tag, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v)
        $display("FAIL %s judge: got %h, expected %h", tag, act_v, exp_v);
      else n_pass++;
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clock);
      n_checks++;
      if ({busy, dbg_state} !== {1'b1, RELEASE})
        $display("FAIL %s release_hold: got busy=%b state=%0d, expected busy=1 state=%0d",
                 tag, busy, dbg_state, RELEASE);
      else n_pass++;
      engine_ready = 1'b0;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (start !== 1'b0) $display("FAIL reset_start: got %b, expected 0", start);
    else n_pass++;
    n_checks++;
    if ({user_choice, comp_choice, result} !== 6'd0)
      $display("FAIL reset_choices: got %h, expected 0", {user_choice, comp_choice, result});
    else n_pass++;
    n_checks++;
    if ({user_score, comp_score, tie_count, game_no} !== 24'd0)
      $display("FAIL reset_counters: got %h, expected 0", {user_score, comp_score, tie_count, game_no});
    else n_pass++;
    n_checks++;
    if ({busy, game_over, err} !== 3'b000)
      $display("FAIL reset_flags: got %b, expected 000", {busy, game_over, err});
    else n_pass++;
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
    else n_pass++;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    play_round(2'b00, 2'b10, 4, 0, "basic");
    n_checks++;
    if (last_lat !== 3) $display("FAIL basic_latency: got %0d, expected 3", last_lat);
    else n_pass++;
  endtask

  task automatic test_sequence();
    apply_reset();
    play_round(2'b01, 2'b10, 2, 0, "seq_win");
    play_round(2'b10, 2'b10, 1, 2, "seq_tie");
    n_checks++;
    if ({result, user_score, tie_count, game_no} !== {2'b11, 6'd1, 6'd1, 6'd2})
      $display("FAIL seq_totals: got %h, expected %h",
               {result, user_score, tie_count, game_no}, {2'b11, 6'd1, 6'd1, 6'd2});
    else n_pass++;
  endtask

  task automatic test_illegal_press();
    int lat;
    logic seen;
    logic [26:0] exp_v, act_v;
    apply_reset();
    user_sel = 2'b11;
    press_and_wait(lat, 12);
    n_checks++;
    if (lat !== 0 || dbg_state !== IDLE)
      $display("FAIL illegal_press: got lat=%0d state=%0d, expected lat=0 state=%0d", lat, dbg_state, IDLE);
    else n_pass++;
    user_sel = 2'b00;
    press_and_wait(lat, 20);
    n_checks++;
    if (lat !== 3) $display("FAIL legal_press_latency: got %0d, expected 3", lat);
    else n_pass++;
    user_sel = 2'b10;
    key_play = 1'b0;
    repeat (4) @(negedge clock);
    key_play = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({start, user_choice, dbg_state} !== {1'b1, 2'b00, WAIT_ENG})
      $display("FAIL second_press: got start=%b user=%b state=%0d, expected start=1 user=00 state=%0d",
               start, user_choice, dbg_state, WAIT_ENG);
    else n_pass++;
    engine_choice = 2'b01;
    engine_ready  = 1'b1;
    model_round(2'b00, 2'b01);
    @(negedge clock);
    engine_ready = 1'b0;
    @(negedge clock);
    act_v = {result, user_score, comp_score, tie_count, game_no, err};
    exp_v = exp_q.pop_front();
    n_checks++;
    if (act_v !== exp_v) $display("FAIL illegal_press_round: got %h, expected %h", act_v, exp_v);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (start === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if ({seen, game_no} !== {1'b0, 6'd1})
      $display("FAIL no_queued_press: got start_seen=%b game_no=%0d, expected 0 and 1", seen, game_no);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int lat;
    int cnt;
    logic [26:0] exp_v, act_v;
    apply_reset();
    play_round(2'b00, 2'b01, 1, 0, "pre_timeout");
    user_sel = 2'b10;
    press_and_wait(lat, 20);
    cnt = (lat != 0) ? 1 : 0;
    while (lat != 0 && cnt < 1100) begin
      @(negedge clock);
      if (start !== 1'b1) break;
      cnt++;
    end
    n_checks++;
    if (cnt !== TMO) $display("FAIL timeout_length: got %0d cycles, expected %0d", cnt, TMO);
    else n_pass++;
    m_err = 1'b1;
    exp_q.push_back({2'b00, m_user, m_comp, m_tie, m_game, m_err});
    act_v = {result, user_score, comp_score, tie_count, game_no, err};
    exp_v = exp_q.pop_front();
    n_checks++;
    if (act_v !== exp_v) $display("FAIL timeout_outputs: got %h, expected %h", act_v, exp_v);
    else n_pass++;
    n_checks++;
    if ({dbg_state, user_choice} !== {RELEASE, 2'b10})
      $display("FAIL timeout_state: got state=%0d user=%b, expected state=%0d user=10",
               dbg_state, user_choice, RELEASE);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if ({dbg_state, busy} !== {IDLE, 1'b0})
      $display("FAIL timeout_idle: got state=%0d busy=%b, expected state=%0d busy=0", dbg_state, busy, IDLE);
    else n_pass++;
  endtask

  task automatic test_illegal_engine();
    apply_reset();
    play_round(2'b01, 2'b11, 0, 0, "illegal_engine");
  endtask

  task automatic test_max_games();
    int lat;
    apply_reset();
    play_round(2'b00, 2'b01, 1, 0, "max_g1");
    play_round(2'b01, 2'b01, 2, 0, "max_g2");
    play_round(2'b10, 2'b01, 3, 0, "max_g3");
    n_checks++;
    if ({game_over, busy, dbg_state} !== {1'b1, 1'b0, DONE})
      $display("FAIL done_flags: got over=%b busy=%b state=%0d, expected over=1 busy=0 state=%0d",
               game_over, busy, dbg_state, DONE);
    else n_pass++;
    user_sel = 2'b00;
    press_and_wait(lat, 20);
    n_checks++;
    if (lat !== 0) $display("FAIL done_press: got start after %0d cycles, expected none", lat);
    else n_pass++;
    n_checks++;
    if ({result, user_score, comp_score, tie_count, game_no, game_over} !==
        {2'b10, 6'd1, 6'd1, 6'd1, 6'd3, 1'b1})
      $display("FAIL done_frozen: got %h, expected %h",
               {result, user_score, comp_score, tie_count, game_no, game_over},
               {2'b10, 6'd1, 6'd1, 6'd1, 6'd3, 1'b1});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    apply_reset();
    user_sel = 2'b01;
    press_and_wait(lat, 20);
    repeat (2) @(negedge clock);
    n_checks++;
    if ({start, dbg_state} !== {1'b1, WAIT_ENG})
      $display("FAIL mid_pre: got start=%b state=%0d, expected start=1 state=%0d", start, dbg_state, WAIT_ENG);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({start, user_choice, comp_choice, result, user_score, comp_score, tie_count,
         game_no, busy, game_over, err} !== 34'd0)
      $display("FAIL mid_reset: got %h, expected 0",
               {start, user_choice, comp_choice, result, user_score, comp_score, tie_count,
                game_no, busy, game_over, err});
    else n_pass++;
    reset = 1'b1;
    model_reset();
    play_round(2'b01, 2'b10, 3, 0, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_illegal_press();
    test_timeout();
    test_illegal_engine();
    test_max_games();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
